// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file. It owns the single write
// port. After reset it clears x1..x31, then shares the port between NUM_REQ
// writeback requesters using round-robin arbitration with valid/ready handshakes.
module regfile_wb_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [5*NUM_REQ-1:0]  req_addr,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rf_we,
  output logic [4:0]            rf_addr,
  output logic [31:0]           rf_wdata,
  output logic                  init_done,
  output logic [2:0]            grant_id
);

  typedef enum logic {S_CLEAR, S_ARB} state_e;

  localparam state_e     RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_ARB;
  localparam logic [2:0] RST_PTR   = 3'(NUM_REQ - 1);

  state_e      state_q, state_d;
  logic [4:0]  clr_cnt_q, clr_cnt_d;
  logic [2:0]  ptr_q, ptr_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_addr_q, rf_addr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        init_done_q, init_done_d;
  logic [2:0]  grant_id_q, grant_id_d;

  logic        gnt_vld;
  logic [2:0]  gnt_idx;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;

  // Round-robin pick: scan from ptr+1 with wrap, and grant the first valid requester.
  // A grant is possible only after init_done. This keeps the port closed for the
  // whole clear and for the first cycle after reset when no clear runs.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    gnt_addr  = '0;
    gnt_data  = '0;
    req_ready = '0;
    if (state_q == S_ARB && init_done_q) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!gnt_vld && i == (int'(ptr_q) + k) % NUM_REQ && req_valid[i]) begin
            gnt_vld      = 1'b1;
            gnt_idx      = 3'(i);
            gnt_addr     = req_addr[5*i +: 5];
            gnt_data     = req_data[32*i +: 32];
            req_ready[i] = 1'b1;
          end
        end
      end
    end
  end

  // Next-state logic: the clear walks x1..x31, then the arbiter moves one granted write per cycle.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    ptr_d       = ptr_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_wdata_d  = rf_wdata_q;
    init_done_d = init_done_q;
    grant_id_d  = grant_id_q;
    unique case (state_q)
      S_CLEAR: begin
        rf_we_d    = 1'b1;
        rf_addr_d  = clr_cnt_q;
        rf_wdata_d = '0;
        clr_cnt_d  = clr_cnt_q + 5'd1;
        if (clr_cnt_q == 5'd31) begin
          state_d     = S_ARB;
          init_done_d = 1'b1;
        end
      end
      S_ARB: begin
        init_done_d = 1'b1;
        if (gnt_vld) begin
          // A write to x0 is consumed (the pointer advances) but never reaches the file.
          rf_we_d    = (gnt_addr != 5'd0);
          rf_addr_d  = gnt_addr;
          rf_wdata_d = gnt_data;
          grant_id_d = gnt_idx;
          ptr_d      = gnt_idx;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  // State and output registers. Reset drops rf_we at once and restarts the clear from x1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= 5'd1;
      ptr_q       <= RST_PTR;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_wdata_q  <= '0;
      init_done_q <= 1'b0;
      grant_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      ptr_q       <= ptr_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_wdata_q  <= rf_wdata_d;
      init_done_q <= init_done_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_addr   = rf_addr_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_done = init_done_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed clear/handshake/x0/reset steps plus a
// randomized phase, all scored against a queue-free round-robin model.
module tb_regfile_wb_arbiter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req_valid;
  logic [5*N-1:0]  req_addr;
  logic [32*N-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          rf_we;
  logic [4:0]    rf_addr;
  logic [31:0]   rf_wdata;
  logic          init_done;
  logic [2:0]    grant_id;

  // second build without the clear sequence
  logic          rstn2;
  logic [N-1:0]  v2;
  logic [5*N-1:0]  a2;
  logic [32*N-1:0] d2;
  logic [N-1:0]  rdy2;
  logic          we2;
  logic [4:0]    addr2;
  logic [31:0]   wdata2;
  logic          done2;
  logic [2:0]    gid2;

  int nchk = 0;
  int nfail = 0;

  // model state
  bit          pv [N];
  logic [4:0]  pa [N];
  logic [31:0] pd [N];
  int          mptr;
  int          last_g;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .init_done(init_done), .grant_id(grant_id));

  regfile_wb_arbiter #(.NUM_REQ(N), .CLEAR_ON_RESET(1'b0)) dut2 (
    .clk(clk), .rstn(rstn2), .req_valid(v2), .req_addr(a2),
    .req_data(d2), .req_ready(rdy2), .rf_we(we2), .rf_addr(addr2),
    .rf_wdata(wdata2), .init_done(done2), .grant_id(gid2));

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk(32'($onehot0(req_ready)), 32'd1, "inv_onehot0");
      if (init_done !== 1'b1) chk(32'(req_ready), 32'd0, "inv_ready_before_init");
      if (rf_we === 1'b1) chk(32'(rf_addr != 5'd0), 32'd1, "inv_we_not_x0");
    end
  end

  task automatic drive();
    for (int j = 0; j < N; j++) begin
      req_valid[j]         = pv[j];
      req_addr[5*j +: 5]   = pa[j];
      req_data[32*j +: 32] = pd[j];
    end
  endtask

  // One arbitration cycle: predict the grant from the pending set, check ready,
  // clock, and check the registered write.
  task automatic step();
    int g;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (mptr + k) % N;
      if (g < 0 && pv[j]) g = j;
    end
    drive();
    #1;
    chk(32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g), "ready");
    @(posedge clk); #1;
    last_g = g;
    if (g >= 0) begin
      m_addr = pa[g];
      m_data = pd[g];
      mptr   = g;
      pv[g]  = 1'b0;
      chk(32'(rf_we), 32'(m_addr != 5'd0), "rf_we_grant");
      chk(32'(grant_id), 32'(g), "grant_id");
    end else begin
      chk(32'(rf_we), 32'd0, "rf_we_idle");
    end
    chk(32'(rf_addr), 32'(m_addr), "rf_addr");
    chk(rf_wdata, m_data, "rf_wdata");
  endtask

  // Clear sequence after reset release. Requests are held valid the whole
  // time to prove the port stays closed.
  task automatic do_clear();
    req_valid = '1;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk); #1;
      chk(32'(rf_we), 32'd1, "clr_we");
      chk(32'(rf_addr), 32'(k), "clr_addr");
      chk(rf_wdata, 32'd0, "clr_wdata");
      if (k < 31) begin
        chk(32'(req_ready), 32'd0, "clr_ready");
        chk(32'(init_done), 32'd0, "clr_init_low");
      end
    end
    req_valid = '0;
    for (int j = 0; j < N; j++) pv[j] = 1'b0;
    @(posedge clk); #1;
    chk(32'(init_done), 32'd1, "init_done");
    chk(32'(rf_we), 32'd0, "post_clr_we");
    mptr = N - 1; m_addr = 5'd31; m_data = '0;
  endtask

  initial begin
    bit found;
    rstn = 1'b0; rstn2 = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    v2 = '0; a2 = '0; d2 = '0;
    for (int j = 0; j < N; j++) begin pv[j] = 0; pa[j] = 0; pd[j] = 0; end
    mptr = N - 1; last_g = -1; m_addr = '0; m_data = '0;

    // reset state
    #3;
    chk(32'(rf_we), 32'd0, "rst_we");
    chk(32'(rf_addr), 32'd0, "rst_addr");
    chk(rf_wdata, 32'd0, "rst_wdata");
    chk(32'(init_done), 32'd0, "rst_init");
    chk(32'(grant_id), 32'd0, "rst_gid");
    @(negedge clk); rstn = 1'b1;
    do_clear();

    // round robin: all valid, addrs 1,2,3
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < N; j++) begin pv[j] = 1; pa[j] = 5'(j + 1); pd[j] = 32'(100 + j); end
      step();
      chk(32'(last_g), 32'(i % 3), "rr_order");
      chk(32'(rf_addr), 32'(i % 3 + 1), "rr_addr");
    end
    for (int j = 0; j < N; j++) pv[j] = 0;

    // single write from requester 1
    pv[1] = 1; pa[1] = 5'd5; pd[1] = 32'hDEADBEEF;
    step();
    chk(32'(rf_addr), 32'd5, "single_addr");
    chk(rf_wdata, 32'hDEADBEEF, "single_data");
    chk(32'(grant_id), 32'd1, "single_gid");

    // x0 write from requester 2 is consumed and dropped
    pv[2] = 1; pa[2] = 5'd0; pd[2] = 32'hFFFFFFFF;
    step();
    chk(32'(rf_we), 32'd0, "x0_we");
    chk(32'(grant_id), 32'd2, "x0_gid");
    for (int j = 0; j < N; j++) begin pv[j] = 1; pa[j] = 5'(9 + j); pd[j] = 32'(j); end
    step();
    chk(32'(last_g), 32'd0, "x0_ptr_adv");

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < N; j++) begin
        if (!pv[j] && $urandom_range(0, 1) == 1) begin
          pv[j] = 1; pa[j] = 5'($urandom_range(0, 31)); pd[j] = $urandom;
        end
      end
      step();
    end
    for (int j = 0; j < N; j++) pv[j] = 0;
    drive();

    // reset in the middle of the clear
    rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    found = 0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(posedge clk); #1;
      if (rf_addr == 5'd12) found = 1;
    end
    chk(32'(found), 32'd1, "mid_clr_seen");
    #2; rstn = 1'b0; #1;
    chk(32'(rf_we), 32'd0, "mid_rst_we");
    chk(32'(rf_addr), 32'd0, "mid_rst_addr");
    chk(32'(init_done), 32'd0, "mid_rst_init");
    @(negedge clk); rstn = 1'b1;
    do_clear();

    // build without clear: request present at release
    v2 = 3'b001; a2[4:0] = 5'd7; d2[31:0] = 32'h1;
    @(negedge clk); rstn2 = 1'b1;
    @(posedge clk); #1;
    chk(32'(done2), 32'd1, "nc_init");
    chk(32'(we2), 32'd0, "nc_we_first");
    chk(32'(rdy2), 32'd1, "nc_ready");
    @(posedge clk); #1;
    v2 = '0;
    chk(32'(we2), 32'd1, "nc_we");
    chk(32'(addr2), 32'd7, "nc_addr");
    chk(wdata2, 32'h1, "nc_data");
    chk(32'(gid2), 32'd0, "nc_gid");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
